// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the EX-stage divider: FSM state encodings, the
// start/stop and ready handshake levels, and the ALU op codes EX uses to
// select DIV / DIVU. Also holds the small sign-correction helper.
// -----------------------------------------------------------------------------
package div_unit_pkg;

  // Divider FSM states
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Start request levels driven by EX
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // Result handshake levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // ALU op codes that route an instruction to this block
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Quotient is negated when exactly one operand is negative (signed mode only;
  // the negative flags are already qualified by the signed-mode select).
  function automatic logic quo_negate(input logic dividend_neg, input logic divisor_neg);
    return dividend_neg ^ divisor_neg;
  endfunction

endpackage

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider serving DIV / DIVU for the EX stage.
// EX holds start_i with latched operands, stalls while busy_o is high, and
// consumes the {remainder, quotient} result when ready_o is seen.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous, active-low reset
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU
//   op1_i         dividend
//   op2_i         divisor
//   start_i       request, held by EX until ready_o
//   annul_i       flush / abort (highest priority after reset)
//   result_o      {remainder (HI), quotient (LO)}, registered
//   ready_o       result valid, registered
//   busy_o        high whenever the FSM is not idle (combinational)
// -----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      signed_div_i,
  input  logic [DATA_WIDTH-1:0]     op1_i,
  input  logic [DATA_WIDTH-1:0]     op2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [2*DATA_WIDTH-1:0]   result_o,
  output logic                      ready_o,
  output logic                      busy_o
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [W-1:0]     ZERO_W    = {W{1'b0}};
  localparam logic [2*W-1:0]   ZERO_2W   = {(2*W){1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_WIDTH - 1);

  // Two's complement negate of a W-bit value
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // State and datapath registers
  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_work;      // {rem, quo} between iterations
  logic [W-1:0]     r_divisor;   // divisor magnitude
  logic             r_neg_quo;
  logic             r_neg_rem;
  logic [2*W-1:0]   r_result;
  logic             r_ready;

  // Next-state values
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2*W-1:0]   w_work_nxt;
  logic [W-1:0]     w_divisor_nxt;
  logic             w_neg_quo_nxt;
  logic             w_neg_rem_nxt;
  logic [2*W-1:0]   w_result_nxt;
  logic             w_ready_nxt;

  // Operand conditioning and one iteration of the datapath
  logic             w_op1_neg;
  logic             w_op2_neg;
  logic [W-1:0]     w_op1_mag;
  logic [W-1:0]     w_op2_mag;
  logic [2*W:0]     w_shift;
  logic [W:0]       w_diff;
  logic [2*W-1:0]   w_step;
  logic [W-1:0]     w_quo_fix;
  logic [W-1:0]     w_rem_fix;

  assign w_op1_neg = signed_div_i & op1_i[W-1];
  assign w_op2_neg = signed_div_i & op2_i[W-1];
  assign w_op1_mag = w_op1_neg ? neg_w(op1_i) : op1_i;
  assign w_op2_mag = w_op2_neg ? neg_w(op2_i) : op2_i;

  // The remainder stays below the divisor, so after the shift the top W+1 bits
  // are below 2*divisor and the MSB of the (W+1)-bit difference is its sign.
  assign w_shift = {r_work, 1'b0};
  assign w_diff  = w_shift[2*W:W] - {1'b0, r_divisor};

  // Restoring step: keep the difference and set the quotient bit, or keep the shifted value
  always_comb begin
    w_step = w_shift[2*W-1:0];
    if (w_diff[W] == 1'b0) begin
      w_step = {w_diff[W-1:0], w_shift[W-1:1], 1'b1};
    end else begin
      w_step = w_shift[2*W-1:0];
    end
  end

  // Sign correction applied to the final step; the most-negative quotient
  // negates onto itself, so 0x80000000 / -1 needs no special case.
  assign w_quo_fix = r_neg_quo ? neg_w(w_step[W-1:0])   : w_step[W-1:0];
  assign w_rem_fix = r_neg_rem ? neg_w(w_step[2*W-1:W]) : w_step[2*W-1:W];

  // FSM next-state and datapath next values
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_neg_quo_nxt = r_neg_quo;
    w_neg_rem_nxt = r_neg_rem;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;

    case (r_state)
      DIV_FREE: begin
        w_result_nxt = ZERO_2W;
        w_ready_nxt  = DIV_RESULT_NOT_READY;
        w_cnt_nxt    = CNT_ZERO;
        if ((start_i == DIV_START) && (annul_i == 1'b0)) begin
          w_divisor_nxt = w_op2_mag;
          w_work_nxt    = {ZERO_W, w_op1_mag};
          w_neg_quo_nxt = quo_negate(w_op1_neg, w_op2_neg);
          w_neg_rem_nxt = w_op1_neg;
          if (op2_i == ZERO_W) begin
            w_state_nxt = DIV_BY_ZERO;
          end else begin
            w_state_nxt = DIV_ON;
          end
        end else begin
          w_state_nxt = DIV_FREE;
        end
      end

      DIV_BY_ZERO: begin
        if (annul_i == 1'b1) begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = CNT_ZERO;
          w_result_nxt = ZERO_2W;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else begin
          // Zero result is staged here; ready is raised from END one edge later
          w_state_nxt  = DIV_END;
          w_result_nxt = ZERO_2W;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end
      end

      DIV_ON: begin
        if (annul_i == 1'b1) begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = CNT_ZERO;
          w_result_nxt = ZERO_2W;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else if (r_cnt == CNT_LAST) begin
          w_work_nxt   = w_step;
          w_state_nxt  = DIV_END;
          w_cnt_nxt    = CNT_ZERO;
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = DIV_RESULT_READY;
        end else begin
          w_work_nxt   = w_step;
          w_cnt_nxt    = r_cnt + CNT_ONE;
        end
      end

      DIV_END: begin
        if (annul_i == 1'b1) begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = CNT_ZERO;
          w_result_nxt = ZERO_2W;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else if (start_i == DIV_START) begin
          // Result held; ready stays (or becomes, after a zero divisor) valid
          w_result_nxt = r_result;
          w_ready_nxt  = DIV_RESULT_READY;
        end else begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = CNT_ZERO;
          w_result_nxt = ZERO_2W;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end
      end

      default: begin
        w_state_nxt  = DIV_FREE;
        w_cnt_nxt    = CNT_ZERO;
        w_result_nxt = ZERO_2W;
        w_ready_nxt  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= DIV_FREE;
      r_cnt     <= CNT_ZERO;
      r_work    <= ZERO_2W;
      r_divisor <= ZERO_W;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= ZERO_2W;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_quo <= w_neg_quo_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = (r_state != DIV_FREE);

endmodule
